alarm_msg_sequencer: RTL and testbench
======================================

# alarm_msg_sequencer

Parametrised N-channel emergency alarm controller that replaces the fixed four-switch combinational decoder. It latches alarm requests per channel until acknowledged, arbitrates by fixed priority, drives the status RGB LED with a per-channel colour, and streams the winning channel's text message byte-by-byte from an external message ROM into the UART transmit FIFO, repeating it after a programmable gap. It sits between the board switches/ack buttons and the `uart` write port.

## Interface
Parameters:
- `N_CH`, 4: number of alarm channels; channel 0 has highest priority.
- `MSG_LEN`, 16: maximum message length in bytes per channel.
- `AW`, 6: ROM address width; must satisfy 2^AW >= N_CH*MSG_LEN.
- `CH_RGB`, {3'b110,3'b101,3'b001,3'b100}: packed colour table, channel i at bits [3i+2:3i].
- `GAP_CYCLES`, 16'd50000: idle clocks between message repeats, 1..65535.
- `BLINK_CYCLES`, 24'd5000000: half-period of LED blink, used only with `ALARM_BLINK_EN`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `alarm_in`  in  N_CH  raw alarm switches, asynchronous to `clk`.
- `ack_in`  in  N_CH  per-channel acknowledge, synchronous, level.
- `rom_addr`  out  AW  message ROM address, registered.
- `rom_data`  in  8  ROM byte for `rom_addr`, combinational (valid same cycle).
- `tx_full`  in  1  UART TX FIFO full.
- `wr_uart`  out  1  one-cycle write strobe to UART.
- `w_data`  out  8  byte written when `wr_uart`=1.
- `rgb_out`  out  3  status LED {R,G,B}, registered.
- `alarm_active`  out  1  any channel pending, registered.
- `active_ch`  out  $clog2(N_CH)  index of highest-priority pending channel, registered.

## Operation
- Input path: 2-flop synchroniser per `alarm_in` bit, then rising-edge detect.
- `pending[i]` set on synchronised rising edge of channel i; cleared when `ack_in[i]`=1. Set and ack in the same cycle: set wins. Alarm level held high after ack does not re-set; a new rising edge is required.
- Arbiter: lowest-index set bit of `pending` -> `active_ch`; `alarm_active` = |pending. No pending: `active_ch`=0, `rgb_out`=3'b000.
- `rgb_out` = `CH_RGB[active_ch]` while `alarm_active`.
- FSM states IDLE, SEND, GAP:
  - IDLE: if `alarm_active`, latch `msg_ch`=`active_ch`, `rom_addr`=`msg_ch`*MSG_LEN, `idx`=0 -> SEND; else stay.
  - SEND: `wr_uart` = !`tx_full` && `rom_data`!=8'h00; `w_data`=`rom_data`. On write, `idx`++ and `rom_addr`++. `tx_full`=1 stalls with address held. `rom_data`==8'h00 (terminator, not sent) or write of byte `idx`=MSG_LEN-1 -> GAP with counter loaded to GAP_CYCLES.
  - GAP: counter decrements each cycle; at 1 -> IDLE.
- Preemption only at message boundaries: a message in flight always completes even if its channel is acked or a higher-priority alarm arrives; the next IDLE re-arbitrates.
- Ack of all channels during GAP: FSM returns to IDLE and stays there.

## Timing
- Reset: `rom_addr`=0, `wr_uart`=0, `w_data`=0, `rgb_out`=0, `alarm_active`=0, `active_ch`=0, `pending`=0, state IDLE, synchronisers 0. Reset mid-message abandons it immediately; no partial strobe.
- `alarm_in` rise -> `pending` set after 3 clocks -> `alarm_active`/`rgb_out`/`active_ch` valid 1 clock later.
- `alarm_active` high in IDLE -> first `wr_uart` on the 2nd following clock (IDLE->SEND, then write), if `tx_full`=0.
- Steady state: one byte per clock while `tx_full`=0; a full MSG_LEN message takes MSG_LEN clocks, then exactly GAP_CYCLES clocks in GAP, then 1 clock in IDLE.
- `wr_uart`/`w_data` are combinational from state, `tx_full`, `rom_data`; never asserted outside SEND.

## Configuration
- `ALARM_BLINK_EN` defined: a 24-bit counter toggles a blink phase every BLINK_CYCLES clocks while `alarm_active`; `rgb_out` = colour in phase 1, 3'b000 in phase 0; counter and phase reset to 0 (phase 1 on first alarm) when `alarm_active` falls.
- Undefined: `rgb_out` steady colour; no blink counter is synthesised.

## Test plan
- Channel 2 rise, ROM text "CODE BLUE\0": -> `rgb_out`=CH_RGB[2] after 4 clocks; 9 strobes "CODE BLUE" on consecutive clocks, no 8'h00 written, repeat after GAP_CYCLES+1.
- Channels 3 then 0 rise mid-message of channel 3: -> channel-3 message completes; next message is channel 0; `rgb_out` switches to CH_RGB[0] 4 clocks after channel-0 rise.
- `tx_full` held high 5 clocks at byte 3: -> no strobe, `rom_addr` frozen; byte 3 sent on first clock after release, no byte lost or duplicated.
- Message with no terminator: -> exactly MSG_LEN strobes, then GAP.
- Ack channel 2 during its message, no other pending: -> message completes, `alarm_active`=0 next clock after ack, FSM stays IDLE after GAP; ack coinciding with a new rising edge leaves `pending[2]`=1.
- `reset` asserted mid-SEND: -> all outputs 0 same cycle, pending cleared, no strobe until a new alarm edge.

Source files
------------

// File: rtl/alarm_msg_sequencer.sv
// N-channel alarm latch/arbiter that streams the winning channel's ROM message into a UART FIFO.
// Optional feature: define ALARM_BLINK_EN to blink the status LED instead of holding it steady.
module alarm_msg_sequencer #(
  parameter int                 N_CH         = 4,
  parameter int                 MSG_LEN      = 16,
  parameter int                 AW           = 6,
  parameter logic [3*N_CH-1:0]  CH_RGB       = {3'b110, 3'b101, 3'b001, 3'b100},
  parameter logic [15:0]        GAP_CYCLES   = 16'd50000,
  parameter logic [23:0]        BLINK_CYCLES = 24'd5000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           alarm_in,
  input  logic [N_CH-1:0]           ack_in,
  output logic [AW-1:0]             rom_addr,
  input  logic [7:0]                rom_data,
  input  logic                      tx_full,
  output logic                      wr_uart,
  output logic [7:0]                w_data,
  output logic [2:0]                rgb_out,
  output logic                      alarm_active,
  output logic [$clog2(N_CH)-1:0]   active_ch
);

  localparam int CW = $clog2(N_CH);
  localparam int IW = $clog2(MSG_LEN) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Reject configurations that cannot work at elaboration time.
  if (GAP_CYCLES == 16'd0 || BLINK_CYCLES == 24'd0 || (2 ** AW) < N_CH * MSG_LEN) begin : g_param_check
    $error("alarm_msg_sequencer: invalid parameter set");
  end

  logic [N_CH-1:0] sync1_r;
  logic [N_CH-1:0] sync2_r;
  logic [N_CH-1:0] sync3_r;
  logic [N_CH-1:0] pending_r;
  logic [N_CH-1:0] rise_s;
  logic [N_CH-1:0] pending_nxt_s;
  logic            arb_any_s;
  logic [CW-1:0]   arb_ch_s;
  logic [2:0]      colour_s;
  logic [2:0]      led_s;

  logic [1:0]      state_r;
  logic [IW-1:0]   idx_r;
  logic [15:0]     gap_cnt_r;
  logic            byte_ok_s;

  // Synchroniser, edge detect and pending latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r   <= {N_CH{1'b0}};
      sync2_r   <= {N_CH{1'b0}};
      sync3_r   <= {N_CH{1'b0}};
      pending_r <= {N_CH{1'b0}};
    end else begin
      sync1_r   <= alarm_in;
      sync2_r   <= sync1_r;
      sync3_r   <= sync2_r;
      pending_r <= pending_nxt_s;
    end
  end

  // Set beats ack; the loop runs high-to-low so the lowest pending index wins.
  always_comb begin
    rise_s        = sync2_r & ~sync3_r;
    pending_nxt_s = (pending_r & ~ack_in) | rise_s;
    arb_any_s     = |pending_r;
    arb_ch_s      = {CW{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      arb_ch_s = pending_r[i] ? CW'(i) : arb_ch_s;
    end
    colour_s = CH_RGB[3*arb_ch_s +: 3];
  end

`ifdef ALARM_BLINK_EN
  logic [23:0] blink_cnt_r;
  logic        blink_phase_r;
  logic [23:0] blink_cnt_nxt_s;
  logic        blink_phase_nxt_s;

  // Blink phase starts lit on a fresh alarm and toggles every BLINK_CYCLES clocks.
  always_comb begin
    if (!arb_any_s) begin
      blink_cnt_nxt_s   = 24'd0;
      blink_phase_nxt_s = 1'b0;
    end else if (!alarm_active) begin
      blink_cnt_nxt_s   = 24'd0;
      blink_phase_nxt_s = 1'b1;
    end else if (blink_cnt_r == BLINK_CYCLES - 24'd1) begin
      blink_cnt_nxt_s   = 24'd0;
      blink_phase_nxt_s = ~blink_phase_r;
    end else begin
      blink_cnt_nxt_s   = blink_cnt_r + 24'd1;
      blink_phase_nxt_s = blink_phase_r;
    end
    led_s = (arb_any_s && blink_phase_nxt_s) ? colour_s : 3'b000;
  end

  // Blink counter and phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r   <= 24'd0;
      blink_phase_r <= 1'b0;
    end else begin
      blink_cnt_r   <= blink_cnt_nxt_s;
      blink_phase_r <= blink_phase_nxt_s;
    end
  end
`else
  // Steady colour for the winning channel.
  always_comb begin
    led_s = arb_any_s ? colour_s : 3'b000;
  end
`endif

  // Registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_active <= 1'b0;
      active_ch    <= {CW{1'b0}};
      rgb_out      <= 3'b000;
    end else begin
      alarm_active <= arb_any_s;
      active_ch    <= arb_ch_s;
      rgb_out      <= led_s;
    end
  end

  // The terminator byte is never written, so the strobe gates on a non-zero byte.
  always_comb begin
    byte_ok_s = (rom_data != 8'h00);
    wr_uart   = (state_r == ST_SEND) && !tx_full && byte_ok_s;
    w_data    = wr_uart ? rom_data : 8'h00;
  end

  // Message FSM; arbitration result is sampled only in IDLE so a message always completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rom_addr  <= {AW{1'b0}};
      idx_r     <= {IW{1'b0}};
      gap_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (alarm_active) begin
            state_r  <= ST_SEND;
            rom_addr <= AW'(active_ch) * AW'(MSG_LEN);
            idx_r    <= {IW{1'b0}};
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (!byte_ok_s) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= GAP_CYCLES;
          end else if (!tx_full) begin
            idx_r    <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            rom_addr <= rom_addr + {{(AW-1){1'b0}}, 1'b1};
            if (idx_r == IW'(MSG_LEN - 1)) begin
              state_r   <= ST_GAP;
              gap_cnt_r <= GAP_CYCLES;
            end else begin
              state_r   <= ST_SEND;
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == 16'd1) begin
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_msg_sequencer.sv
// Randomised and directed bench for alarm_msg_sequencer against a message-level reference model.
module tb_alarm_msg_sequencer;

  localparam int MSG_LEN = 16;
  localparam int GAP     = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alarm_in;
  logic [3:0] ack_in;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [2:0] rgb_out;
  logic       alarm_active;
  logic [1:0] active_ch;

  logic [7:0]  rom [64];
  logic [11:0] rgb_tab = {3'b110, 3'b101, 3'b001, 3'b100};
  logic [7:0]  cap [$];

  int total = 0;
  int bad   = 0;

  // Reference model state: alarm history, pending set, and message progress.
  logic [3:0] m_hist [3];
  logic [3:0] m_pend;
  logic       m_active;
  int         m_ch;
  logic [2:0] m_rgb;
  logic       m_in_msg;
  int         m_c;
  int         m_p;
  int         m_gap;

  alarm_msg_sequencer #(
    .N_CH(4), .MSG_LEN(MSG_LEN), .AW(6),
    .CH_RGB({3'b110, 3'b101, 3'b001, 3'b100}),
    .GAP_CYCLES(16'd8), .BLINK_CYCLES(24'd5000000)
  ) dut (
    .clk(clk), .reset(reset), .alarm_in(alarm_in), .ack_in(ack_in),
    .rom_addr(rom_addr), .rom_data(rom_data), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .rgb_out(rgb_out),
    .alarm_active(alarm_active), .active_ch(active_ch)
  );

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] p);
    for (int k = 0; k < 4; k++) if (p[k]) return k;
    return 0;
  endfunction

  function automatic logic [7:0] cur_byte();
    return m_in_msg ? rom[m_c*MSG_LEN + m_p] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_hist[k] = 4'b0000;
    m_pend = 4'b0000; m_active = 1'b0; m_ch = 0; m_rgb = 3'b000;
    m_in_msg = 1'b0; m_c = 0; m_p = 0; m_gap = 0;
  endtask

  // One clock of the specification's rules, all evaluated on pre-edge values.
  task automatic model_edge();
    logic [7:0] b;
    logic [3:0] old_pend;
    logic [3:0] rise;
    b = cur_byte();
    if (m_in_msg) begin
      if (b == 8'h00) begin
        m_in_msg = 1'b0; m_gap = GAP;
      end else if (!tx_full) begin
        m_p++;
        if (m_p == MSG_LEN) begin m_in_msg = 1'b0; m_gap = GAP; end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_active) begin
      m_in_msg = 1'b1; m_c = m_ch; m_p = 0;
    end
    old_pend = m_pend;
    m_active = |old_pend;
    m_ch     = lowest(old_pend);
    m_rgb    = m_active ? rgb_tab[m_ch*3 +: 3] : 3'b000;
    rise     = m_hist[1] & ~m_hist[2];
    m_pend   = (old_pend & ~ack_in) | rise;
    m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = alarm_in;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic [7:0] b;
    logic       ew;
    logic [5:0] ea;
    #1;
    b  = cur_byte();
    ew = m_in_msg && !tx_full && (b != 8'h00);
    chk("wr_uart", wr_uart, ew);
    chk("w_data", w_data, ew ? b : 8'h00);
    if (wr_uart) cap.push_back(w_data);
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    @(negedge clk);
    ea = 6'((m_c*MSG_LEN + m_p) % 64);
    chk("rom_addr", rom_addr, ea);
    chk("alarm_active", alarm_active, m_active);
    chk("active_ch", active_ch, m_ch);
    chk("rgb_out", rgb_out, m_rgb);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic load(input int ch, input string s);
    for (int k = 0; k < s.len(); k++) rom[ch*MSG_LEN + k] = s[k];
  endtask

  initial begin
    string exp_s;
    int    n;
    logic [5:0] held;
    for (int k = 0; k < 64; k++) rom[k] = 8'h00;
    load(0, "FIRE");
    load(1, "SMOKE IN ZONE 7!");
    load(2, "CODE BLUE");
    load(3, "EVACUATE NOW");
    reset = 1'b1; alarm_in = 4'b0000; ack_in = 4'b0000; tx_full = 1'b0;
    model_reset();
    @(negedge clk); #1;
    chk("rst_rom_addr", rom_addr, 6'd0);
    chk("rst_wr_uart", wr_uart, 1'b0);
    chk("rst_rgb", rgb_out, 3'b000);
    chk("rst_active", alarm_active, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run(3);

    // Channel 2: colour after 4 clocks, "CODE BLUE" back to back, repeat after the gap.
    cap.delete();
    alarm_in = 4'b0100;
    run(4);
    chk("ch2_rgb", rgb_out, 3'b101);
    run(10);
    exp_s = "CODE BLUE";
    chk("ch2_count", cap.size(), 9);
    for (int k = 0; k < 9 && k < cap.size(); k++) chk("ch2_text", cap[k], exp_s[k]);
    run(10);
    chk("ch2_gap_quiet", cap.size(), 9);
    run(1);
    chk("ch2_repeat", cap.size(), 10);

    // Ack mid-message: message completes, then the sequencer stays idle.
    alarm_in = 4'b0000; ack_in = 4'b0100;
    run(1);
    ack_in = 4'b0000;
    run(1);
    chk("ack_inactive", alarm_active, 1'b0);
    run(30);
    n = cap.size();
    run(10);
    chk("ack_idle", cap.size(), n);

    // New rising edge coinciding with ack: set wins.
    alarm_in = 4'b0100;
    run(2);
    ack_in = 4'b0100;
    run(1);
    ack_in = 4'b0000;
    run(1);
    chk("set_wins", alarm_active, 1'b1);
    alarm_in = 4'b0000;
    run(12);
    ack_in = 4'b0100;
    run(1);
    ack_in = 4'b0000;
    run(25);

    // Channel 3 then channel 0 mid-message: ch3 completes, ch0 goes next.
    cap.delete();
    alarm_in = 4'b1000;
    run(9);
    alarm_in = 4'b1001;
    run(4);
    chk("pre_rgb", rgb_out, 3'b100);
    chk("pre_ch", active_ch, 2'd0);
    run(40);
    chk("pre_len", cap.size() >= 13, 1'b1);
    if (cap.size() >= 13) begin
      chk("pre_last3", cap[11], 8'h57);
      chk("pre_next0", cap[12], 8'h46);
    end
    alarm_in = 4'b0000; ack_in = 4'b1111;
    run(1);
    ack_in = 4'b0000;
    run(25);

    // Unterminated channel 1 with a 5-clock stall at byte 3.
    cap.delete();
    alarm_in = 4'b0010;
    for (int k = 0; k < 40 && cap.size() < 3; k++) cycle();
    chk("stall_reach", cap.size(), 3);
    held = rom_addr;
    chk("stall_addr", held, 6'd19);
    tx_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_frozen", rom_addr, 6'd19);
    end
    chk("stall_nostrobe", cap.size(), 3);
    tx_full = 1'b0;
    run(1);
    chk("stall_resume", cap.size(), 4);
    if (cap.size() >= 4) chk("stall_byte3", cap[3], rom[19]);
    run(12);
    chk("full_len", cap.size(), 16);
    run(9);
    chk("full_gap", cap.size(), 16);
    run(1);
    chk("full_repeat", cap.size(), 17);
    alarm_in = 4'b0000; ack_in = 4'b0010;
    run(1);
    ack_in = 4'b0000;
    run(30);

    // Reset in the middle of a message.
    alarm_in = 4'b0001;
    run(7);
    #2;
    reset = 1'b1;
    alarm_in = 4'b0000;
    model_reset();
    #1;
    chk("mid_rst_wr", wr_uart, 1'b0);
    chk("mid_rst_addr", rom_addr, 6'd0);
    chk("mid_rst_rgb", rgb_out, 3'b000);
    chk("mid_rst_active", alarm_active, 1'b0);
    @(negedge clk);
    run(2);
    reset = 1'b0;
    n = cap.size();
    run(12);
    chk("post_rst_quiet", cap.size(), n);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) alarm_in = alarm_in ^ (4'b0001 << $urandom_range(0, 3));
      ack_in  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      tx_full = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
